// File: rtl/mem_readback.sv
// Host-side burst reader for the core's byte-wide synchronous RAM.
// While a burst is active the CPU is held off the memory port, each byte is
// fetched in turn and offered to the host on a valid/ack byte channel.
module mem_readback #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] PRESENT = 2'd3;

  // A zero length field stands for the whole memory, so the byte counter
  // needs one bit more than the address.
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_BYTE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] next_addr;

  // Address wraps naturally at the top of memory.
  assign next_addr = addr + 1'b1;

  // The CPU is stalled for exactly as long as a burst owns the RAM port.
  assign cpu_hold = busy;

  // Burst sequencer: fetch, capture, present, then repeat until the count
  // runs out or the host aborts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        mem_re    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              addr      <= start_addr;
              remaining <= (length == '0) ? FULL_COUNT : {1'b0, length};
              mem_re    <= 1'b1;
              mem_addr  <= start_addr;
              busy      <= 1'b1;
              state     <= FETCH;
            end
          end
          FETCH: begin
            mem_re <= 1'b0;
            state  <= CAPTURE;
          end
          CAPTURE: begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
          PRESENT: begin
            if (out_ack && out_valid) begin
              out_valid <= 1'b0;
              remaining <= remaining - 1'b1;
              addr      <= next_addr;
              if (remaining == LAST_BYTE) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                mem_re   <= 1'b1;
                mem_addr <= next_addr;
                state    <= FETCH;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_readback.sv
// Directed bench for mem_readback with a behavioural synchronous RAM.
// All activity happens 1 time unit after the rising edge, so each check
// sees the registered values produced by the edge just passed.
module tb_mem_readback;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] length;
  logic              abort;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_hold;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ack;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  mem_readback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .start_addr(start_addr),
    .length(length), .abort(abort), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .out_data(out_data),
    .out_valid(out_valid), .out_ack(out_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle request, optionally with abort high at the same time.
  task automatic applyStimulus(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] len,
                               input logic with_abort);
    start_addr = sa;
    length     = len;
    req        = 1'b1;
    abort      = with_abort;
    tick();
    req   = 1'b0;
    abort = 1'b0;
  endtask

  // Whole burst with fixed expected latencies; busy_req_at pulses a stray
  // request (start 50, length 1) while that byte index is being presented.
  task automatic readBurst(input logic [ADDR_W-1:0] sa, input int count, input int ack_delay,
                           input int busy_req_at, input logic with_abort);
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] len_field;
    len_field = ADDR_W'(count);
    applyStimulus(sa, len_field, with_abort);
    for (int i = 0; i < count; i++) begin
      a = ADDR_W'(int'(sa) + i);
      checkOutput("mem_re", {31'd0, mem_re}, 32'd1);
      checkOutput("mem_addr", {25'd0, mem_addr}, {25'd0, a});
      checkOutput("busy", {31'd0, busy}, 32'd1);
      checkOutput("cpu_hold", {31'd0, cpu_hold}, 32'd1);
      tick();
      checkOutput("mem_re_low", {31'd0, mem_re}, 32'd0);
      checkOutput("mem_addr_hold", {25'd0, mem_addr}, {25'd0, a});
      checkOutput("valid_early", {31'd0, out_valid}, 32'd0);
      tick();
      checkOutput("out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("out_data", {24'd0, out_data}, {24'd0, ram[a]});
      for (int d = 0; d < ack_delay; d++) begin
        if (i == busy_req_at && d == 0) begin
          start_addr = 7'd50;
          length     = 7'd1;
          req        = 1'b1;
        end
        tick();
        req = 1'b0;
        checkOutput("valid_hold", {31'd0, out_valid}, 32'd1);
        checkOutput("data_hold", {24'd0, out_data}, {24'd0, ram[a]});
      end
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      checkOutput("valid_clear", {31'd0, out_valid}, 32'd0);
      if (i == count - 1) begin
        checkOutput("done", {31'd0, done}, 32'd1);
        checkOutput("busy_end", {31'd0, busy}, 32'd0);
        checkOutput("cpu_hold_end", {31'd0, cpu_hold}, 32'd0);
      end else begin
        checkOutput("no_early_done", {31'd0, done}, 32'd0);
      end
    end
    tick();
    checkOutput("done_pulse", {31'd0, done}, 32'd0);
    checkOutput("idle_mem_re", {31'd0, mem_re}, 32'd0);
  endtask

  // Check the whole output set against the reset values.
  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_mem_re"}, {31'd0, mem_re}, 32'd0);
    checkOutput({tag, "_mem_addr"}, {25'd0, mem_addr}, 32'd0);
    checkOutput({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'(i * 37 + 11);
    ram[5] = 8'hA1;
    ram[6] = 8'hB2;
    ram[7] = 8'hC3;
    ram[9] = 8'h99;

    rst_n = 1'b0; req = 1'b0; start_addr = '0; length = '0; abort = 1'b0; out_ack = 1'b0;
    tick();
    tick();
    checkIdleZero("reset");
    rst_n = 1'b1;
    tick();

    // Short burst, ack two cycles after each valid.
    readBurst(7'd5, 3, 2, -1, 1'b0);

    // Burst across the top of memory.
    readBurst(7'd126, 4, 0, -1, 1'b0);

    // Length zero reads the full memory.
    readBurst(7'd0, 128, 0, -1, 1'b0);

    // Stray request mid-burst must not disturb the running burst.
    readBurst(7'd30, 3, 2, 1, 1'b0);

    // Request and abort together in IDLE: the request wins.
    readBurst(7'd40, 1, 1, -1, 1'b1);

    // Abort while the second byte is presented, with ack also high.
    applyStimulus(7'd20, 7'd5, 1'b0);
    tick();
    tick();
    checkOutput("abort_b1_data", {24'd0, out_data}, {24'd0, ram[20]});
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    checkOutput("abort_b2_addr", {25'd0, mem_addr}, 32'd21);
    tick();
    tick();
    checkOutput("abort_b2_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("abort_b2_data", {24'd0, out_data}, {24'd0, ram[21]});
    abort   = 1'b1;
    out_ack = 1'b1;
    tick();
    abort   = 1'b0;
    out_ack = 1'b0;
    checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("abort_mem_re", {31'd0, mem_re}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    tick();
    checkOutput("abort_done_late", {31'd0, done}, 32'd0);
    checkOutput("abort_stays_idle", {31'd0, mem_re}, 32'd0);
    readBurst(7'd9, 1, 1, -1, 1'b0);

    // Reset asserted while the first byte is being captured.
    applyStimulus(7'd10, 7'd2, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkIdleZero("midreset");
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    checkIdleZero("post_reset_ack");
    tick();
    checkOutput("post_reset_done", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
